// File: rtl/mac_result_quant.sv
// Quantizes signed MAC result lanes (scale, bias, round, shift, saturate), packs pairs of
// input words into one output word of int8 results and buffers them in a small output FIFO.
module mac_result_quant #(
   parameter int GBUS_DATA  = 64,
   parameter int ODATA_BIT  = 16,
   parameter int IDATA_BIT  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_BIT    = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [LEN_BIT-1:0]   cfg_row_words,
   input  logic [ODATA_BIT-1:0] cfg_quant_scale,
   input  logic [ODATA_BIT-1:0] cfg_quant_bias,
   input  logic [ODATA_BIT-1:0] cfg_quant_shift,
   input  logic [GBUS_DATA-1:0] gbus_rdata,
   input  logic                 gbus_rvalid,
   output logic [GBUS_DATA-1:0] out_data,
   output logic                 out_valid,
   output logic                 out_last,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow,
   output logic [1:0]           dbg_state
);

   localparam int LANES = GBUS_DATA / ODATA_BIT;
   localparam int PW    = 2 * ODATA_BIT;
   localparam int SW    = PW + 2;
   localparam int HALF  = LANES * IDATA_BIT;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int EW    = GBUS_DATA + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (IDATA_BIT - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

   // Handshakes: gbus_rvalid has no back-pressure, every RUN-state beat is consumed;
   // an output word transfers on a rising edge where out_valid and out_ready are both 1.

   logic [1:0]                  r_state;
   logic [LEN_BIT-1:0]          r_word_cnt;
   logic [LEN_BIT-1:0]          r_row_words;
   logic signed [ODATA_BIT-1:0] r_scale;
   logic signed [ODATA_BIT-1:0] r_bias;
   logic [4:0]                  r_shift;
   logic                        r_overflow;

   logic                        r_s1_valid, r_s1_odd, r_s1_last;
   logic signed [PW-1:0]        r_s1_prod [LANES];
   logic                        r_s2_valid, r_s2_odd, r_s2_last;
   logic signed [SW-1:0]        r_s2_val [LANES];
   logic                        r_s3_valid, r_s3_odd, r_s3_last;
   logic [HALF-1:0]             r_s3_bytes;
   logic [HALF-1:0]             r_pack_lo;

   logic [EW-1:0]               r_mem [FIFO_DEPTH];
   logic [AW:0]                 r_wr_ptr;
   logic [AW:0]                 r_rd_ptr;

   logic                        w_start_acc;
   logic                        w_empty_row;
   logic                        w_accept;
   logic [LEN_BIT-1:0]          w_cnt_next;
   logic                        w_in_last;
   logic signed [PW-1:0]        w_scale_x;
   logic signed [SW-1:0]        w_bias_x;
   logic signed [SW-1:0]        w_round;
   logic signed [PW-1:0]        w_lane_x [LANES];
   logic signed [PW-1:0]        w_prod [LANES];
   logic signed [SW-1:0]        w_sum [LANES];
   logic signed [SW-1:0]        w_shifted [LANES];
   logic [HALF-1:0]             w_sat_bytes;
   logic                        w_push;
   logic                        w_push_last;
   logic [GBUS_DATA-1:0]        w_push_data;
   logic                        w_empty;
   logic                        w_full;
   logic                        w_pop;
   logic                        w_push_ok;
   logic                        w_drop;
   logic [EW-1:0]               w_head;
   logic                        w_unused_shift;

   assign w_unused_shift = ^cfg_quant_shift[ODATA_BIT-1:5];

   assign w_start_acc = (r_state == S_IDLE) && start;
   assign w_empty_row = (r_state == S_RUN) && (r_row_words == '0);
   assign w_accept    = (r_state == S_RUN) && gbus_rvalid && !w_empty_row;
   assign w_cnt_next  = r_word_cnt + LEN_BIT'(1);
   assign w_in_last   = (w_cnt_next == r_row_words);

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_state     <= S_IDLE;
         r_word_cnt  <= '0;
         r_row_words <= '0;
         r_scale     <= '0;
         r_bias      <= '0;
         r_shift     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_row_words <= cfg_row_words;
                  r_scale     <= cfg_quant_scale;
                  r_bias      <= cfg_quant_bias;
                  r_shift     <= cfg_quant_shift[4:0];
                  r_word_cnt  <= '0;
                  r_state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_empty_row) begin
                  r_state <= S_IDLE;
               end else if (gbus_rvalid) begin
                  r_word_cnt <= w_cnt_next;
                  if (w_in_last) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_push_last) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rstn)             r_overflow <= 1'b0;
      else if (w_start_acc) r_overflow <= 1'b0;
      else if (w_drop)      r_overflow <= 1'b1;
   end

   assign w_scale_x = {{(PW-ODATA_BIT){r_scale[ODATA_BIT-1]}}, r_scale};
   assign w_bias_x  = {{(SW-ODATA_BIT){r_bias[ODATA_BIT-1]}}, r_bias};
   assign w_round   = (r_shift == 5'd0) ? '0 : (SW'(1) << (r_shift - 5'd1));

   // Two guard bits above the product keep product + bias + round from wrapping.
   always_comb begin
      w_sat_bytes = '0;
      for (int k = 0; k < LANES; k++) begin
         w_lane_x[k]  = {{(PW-ODATA_BIT){gbus_rdata[k*ODATA_BIT+ODATA_BIT-1]}},
                         gbus_rdata[k*ODATA_BIT +: ODATA_BIT]};
         w_prod[k]    = w_lane_x[k] * w_scale_x;
         w_sum[k]     = {{2{r_s1_prod[k][PW-1]}}, r_s1_prod[k]} + w_bias_x + w_round;
         w_shifted[k] = w_sum[k] >>> r_shift;
         if (r_s2_val[k] > SAT_MAX)
            w_sat_bytes[k*IDATA_BIT +: IDATA_BIT] = SAT_MAX[IDATA_BIT-1:0];
         else if (r_s2_val[k] < SAT_MIN)
            w_sat_bytes[k*IDATA_BIT +: IDATA_BIT] = SAT_MIN[IDATA_BIT-1:0];
         else
            w_sat_bytes[k*IDATA_BIT +: IDATA_BIT] = r_s2_val[k][IDATA_BIT-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_s1_valid <= 1'b0;
         r_s1_odd   <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_odd   <= 1'b0;
         r_s2_last  <= 1'b0;
         r_s3_valid <= 1'b0;
         r_s3_odd   <= 1'b0;
         r_s3_last  <= 1'b0;
         r_s3_bytes <= '0;
         r_pack_lo  <= '0;
         for (int k = 0; k < LANES; k++) begin
            r_s1_prod[k] <= '0;
            r_s2_val[k]  <= '0;
         end
      end else begin
         r_s1_valid <= w_accept;
         r_s1_odd   <= r_word_cnt[0];
         r_s1_last  <= w_in_last;
         r_s2_valid <= r_s1_valid;
         r_s2_odd   <= r_s1_odd;
         r_s2_last  <= r_s1_last;
         r_s3_valid <= r_s2_valid;
         r_s3_odd   <= r_s2_odd;
         r_s3_last  <= r_s2_last;
         r_s3_bytes <= w_sat_bytes;
         for (int k = 0; k < LANES; k++) begin
            r_s1_prod[k] <= w_prod[k];
            r_s2_val[k]  <= w_shifted[k];
         end
         if (r_s3_valid && !r_s3_odd) r_pack_lo <= r_s3_bytes;
      end
   end

   // An even word waits in r_pack_lo unless it closes the row, then it goes out alone.
   assign w_push      = r_s3_valid && (r_s3_odd || r_s3_last);
   assign w_push_last = w_push && r_s3_last;
   assign w_push_data = r_s3_odd ? {r_s3_bytes, r_pack_lo}
                                 : {{(GBUS_DATA-HALF){1'b0}}, r_s3_bytes};

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop     = !w_empty && out_ready;
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_drop    = w_push && w_full && !w_pop;
   assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_push_last, w_push_data};
            r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   assign out_valid = !w_empty;
   assign out_data  = w_empty ? '0 : w_head[GBUS_DATA-1:0];
   assign out_last  = !w_empty && w_head[GBUS_DATA];
   assign busy      = (r_state != S_IDLE) || !w_empty;
   assign done      = ((r_state == S_DRAIN) && w_push_last) || w_empty_row;
   assign overflow  = r_overflow;
   assign dbg_state = r_state;

endmodule

// File: doc/mac_result_quant.md
MAC_RESULT_QUANT -- requirements
Module: mac_result_quant

Interface
REQ-001 SHALL have parameter GBUS_DATA, default 64, meaning input/output bus width in bits.
REQ-002 SHALL have parameter ODATA_BIT, default 16, meaning signed MAC result lane width.
REQ-003 SHALL have parameter IDATA_BIT, default 8, meaning quantized output lane width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of 2).
REQ-005 SHALL have parameter LEN_BIT, default 8, meaning row-length counter width.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rstn, input, 1, reset; synchronous, active-high (rstn=1 resets).
REQ-008 SHALL have port start, input, 1, row start strobe.
REQ-009 SHALL have port cfg_row_words, input, LEN_BIT, number of input words in the row.
REQ-010 SHALL have ports cfg_quant_scale, cfg_quant_bias and cfg_quant_shift, input, ODATA_BIT each, signed scale, signed bias and unsigned shift (bits [4:0] used).
REQ-011 SHALL have port gbus_rdata, input, GBUS_DATA, 4 signed 16-bit lanes; lane k = bits [16k+15:16k].
REQ-012 SHALL have port gbus_rvalid, input, 1, gbus_rdata valid; there is no ready.
REQ-013 SHALL have port out_data, output, GBUS_DATA, 8 packed int8 results.
REQ-014 SHALL have ports out_valid and out_last, output, 1 each; out_ready, input, 1.
REQ-015 SHALL have ports busy, done and overflow, output, 1 each.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and DRAIN.
REQ-017 SHALL latch all cfg_* inputs when start=1 in IDLE, clear overflow and the word counter, and go to RUN; start in RUN or DRAIN is ignored.
REQ-018 In IDLE, gbus_rvalid SHALL be ignored: no push, no overflow.
REQ-019 In RUN, each gbus_rvalid SHALL increment the input word counter; when the counter reaches cfg_row_words the FSM goes to DRAIN.
REQ-020 Per lane, arithmetic SHALL be: p = lane*scale, 32-bit signed; s = p + sign-extended bias, 33-bit; r = (s + (shift>0 ? 2^(shift-1) : 0)) >>> shift; q = clamp(r, -128, 127).
REQ-021 The quantizer SHALL be a 3-stage pipeline: multiply; bias+round+shift; saturate.
REQ-022 The packer SHALL place even-indexed word lane k in byte k and odd-indexed word lane k in byte 4+k, then push to the FIFO after each odd word.
REQ-023 If the row has an odd number of words, the final word SHALL be pushed with bytes 7..4 = 0.
REQ-024 out_last SHALL be 1 only on the final pushed word of a row.
REQ-025 A word completing a pair SHALL produce out_valid 4 cycles after its gbus_rvalid cycle, provided the FIFO was empty.
REQ-026 DRAIN SHALL wait until the pipeline and packer are empty, pulse done for 1 cycle in the cycle the final word is pushed, then return to IDLE.
REQ-027 cfg_row_words=0 SHALL pulse done in the cycle after start and produce no output.
REQ-028 out_valid SHALL equal FIFO not-empty; a pop occurs on out_valid&out_ready.
REQ-029 A push into a full FIFO with a pop in the same cycle SHALL be accepted.
REQ-030 A push into a full FIFO without a pop SHALL drop the word and set overflow; overflow is sticky until reset or the next accepted start.
REQ-031 busy SHALL be 1 whenever state is not IDLE or the FIFO is non-empty.

Reset
REQ-032 rstn=1 SHALL force state IDLE, empty the FIFO, flush the pipeline and packer, zero the counter and latched cfg, and drive out_valid=0, out_last=0, done=0, overflow=0, busy=0 and out_data=0.
REQ-033 Reset mid-row SHALL discard all in-flight data; no output appears after reset until a new start.

Verification
REQ-034 Saturation: scale=1, bias=0, shift=0, rows=2; words {5,-3,127,200} and {-200,0,1,-1} -> out_data=0xFF0100807F7FFD05, last=1, valid at +4 cycles, done pulse.
REQ-035 Rounding: scale=1, bias=0, shift=1; lanes {3,-3,1,-1} and {2,0,0,0}, rows=2 -> bytes 0..4 = 02,FF,01,00,01; bias=4 with shift=0 and lane 0 -> byte 04.
REQ-036 Odd row: rows=3 -> 2 output words; the second has upper 4 bytes 0 and last=1; the first has last=0.
REQ-037 Backpressure: out_ready=0, rows=12 -> 4 words held, 2 dropped, overflow=1; next start clears it.
REQ-038 Reset mid-row: pulse rstn after 3 of 8 words -> out_valid=0, busy=0 next cycle, and further gbus_rvalid is ignored until start.
